fp_sqrt_iter: RTL and testbench

- Parametrised, iterative IEEE-754 square-root unit. It replaces the fixed single-precision series-approximation root with an exactly rounded, digit-recurrence root.
- Restoring radix-2 recurrence produces one root bit per clock.
- Start/enable handshake; special operands are handled explicitly.
- Sits in the calculator datapath beside the add/mult units and drives the shared result bus.

---
 rtl/fp_sqrt_iter_if.sv | 17 +
 rtl/fp_sqrt_iter.sv | 161 ++++++++++++++++
 tb/tb_fp_sqrt_iter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_sqrt_iter_if.sv
// Handshake and result bus of the iterative square-root unit.
// The calculator sequencer is the master; the root unit is the slave.
interface fp_sqrt_iter_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    logic                  start;
    logic [EXP_W+FRAC_W:0] A;
    logic                  busy;
    logic                  enable;
    logic [EXP_W+FRAC_W:0] result;
    logic                  invalid;
    logic                  underflow;

    modport master (output start, A, input busy, enable, result, invalid, underflow);
    modport slave  (input start, A, output busy, enable, result, invalid, underflow);
endinterface

// File: rtl/fp_sqrt_iter.sv
// Exactly rounded IEEE-754 square root, restoring radix-2 recurrence, one root bit per clock.
// Special operands bypass the recurrence and reach DONE through ROUND so they take two cycles.
module fp_sqrt_iter #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic          CLK,
    input  logic          RST,
    fp_sqrt_iter_if.slave io
);
    localparam int W  = EXP_W + FRAC_W + 1;
    localparam int N  = FRAC_W + 2;
    localparam int CW = $clog2(N + 1);
    localparam logic [EXP_W-1:0] BIAS = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic [W-1:0]     QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             spec_q, spec_d;
    logic [2*N-1:0]   rad_q, rad_d;
    logic [N+1:0]     rem_q, rem_d;
    logic [N-1:0]     root_q, root_d;
    logic [EXP_W-1:0] er_q, er_d;
    logic [W-1:0]     result_q, result_d;
    logic             invalid_q, invalid_d;
    logic             underflow_q, underflow_d;
    logic             busy_c, enable_c;

    logic             op_sgn;
    logic [EXP_W-1:0] op_exp;
    logic [FRAC_W-1:0] op_frac;
    logic             exp_ones, exp_zero, frac_zero, special;
    logic [W-1:0]     spec_res;
    logic             spec_inv, spec_unf;
    logic [EXP_W:0]   exp_sum;
    logic [N-1:0]     rad_top;

    assign {op_sgn, op_exp, op_frac} = io.A;
    assign exp_ones  = &op_exp;
    assign exp_zero  = ~|op_exp;
    assign frac_zero = ~|op_frac;
    assign special   = exp_ones | exp_zero | op_sgn;

    // floor((exp+BIAS)/2) == floor((exp-BIAS)/2)+BIAS, and its LSB gives the parity of the unbiased exponent.
    assign exp_sum = {1'b0, op_exp} + {1'b0, BIAS};
    assign rad_top = exp_sum[0] ? {1'b1, op_frac, 1'b0} : {2'b01, op_frac};

    always_comb begin
        spec_res = QNAN;
        spec_inv = 1'b0;
        spec_unf = 1'b0;
        if (exp_ones && !frac_zero) begin
            spec_res = {op_sgn, {EXP_W{1'b1}}, 1'b1, op_frac[FRAC_W-2:0]};
        end else if (exp_zero) begin
            spec_res = {op_sgn, {(W-1){1'b0}}};
            spec_unf = !frac_zero;
        end else if (op_sgn) begin
            spec_inv = 1'b1;
        end else begin
            spec_res = {1'b0, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end
    end

    logic [N+1:0]     rem_sh, trial;
    logic             take;
    logic [N-1:0]     mant;
    logic [EXP_W-1:0] er_rnd;

    assign rem_sh = {rem_q[N-1:0], rad_q[2*N-1 -: 2]};
    assign trial  = {root_q, 2'b01};
    assign take   = (|rem_q[N+1:N]) || (rem_sh >= trial);

    // mant[N-1:FRAC_W] is 01 normally and 10 after a carry-out, so minus one is the exponent bump.
    assign mant   = {1'b0, root_q[N-1:1]} + {{(N-1){1'b0}}, root_q[0]};
    assign er_rnd = er_q + EXP_W'(mant[N-1:FRAC_W]) - EXP_W'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (io.start) state_d = special ? ROUND : CALC;
            CALC:    if (cnt_q == CW'(1)) state_d = ROUND;
            ROUND:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_c   = (state_q != IDLE);
        enable_c = (state_q == DONE);
    end

    always_comb begin
        cnt_d       = cnt_q;
        spec_d      = spec_q;
        rad_d       = rad_q;
        rem_d       = rem_q;
        root_d      = root_q;
        er_d        = er_q;
        result_d    = result_q;
        invalid_d   = invalid_q;
        underflow_d = underflow_q;
        case (state_q)
            IDLE: if (io.start) begin
                spec_d      = special;
                cnt_d       = CW'(N);
                rad_d       = {rad_top, {N{1'b0}}};
                rem_d       = '0;
                root_d      = '0;
                er_d        = exp_sum[EXP_W:1];
                result_d    = special ? spec_res : result_q;
                invalid_d   = special & spec_inv;
                underflow_d = special & spec_unf;
            end
            CALC: begin
                cnt_d  = cnt_q - CW'(1);
                rad_d  = rad_q << 2;
                rem_d  = take ? (rem_sh - trial) : rem_sh;
                root_d = {root_q[N-2:0], take};
            end
            // Guard-bit round-up equals round-to-nearest-even: a square root never lands on a tie.
            ROUND: if (!spec_q) result_d = {1'b0, er_rnd, mant[FRAC_W-1:0]};
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q       <= '0;
            spec_q      <= 1'b0;
            result_q    <= '0;
            invalid_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            spec_q      <= spec_d;
            result_q    <= result_d;
            invalid_q   <= invalid_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        rad_q  <= rad_d;
        rem_q  <= rem_d;
        root_q <= root_d;
        er_q   <= er_d;
    end

    assign io.busy      = busy_c;
    assign io.enable    = enable_c;
    assign io.result    = result_q;
    assign io.invalid   = invalid_q;
    assign io.underflow = underflow_q;
endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Scoreboard bench for fp_sqrt_iter: single-precision and half-precision instances,
// directed vectors plus a half-precision sweep against a real-valued root model.
module tb_fp_sqrt_iter;
    localparam int S_LAT  = 27;
    localparam int H_LAT  = 14;
    localparam int SP_LAT = 2;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    fp_sqrt_iter_if #(.EXP_W(8), .FRAC_W(23)) s_if ();
    fp_sqrt_iter_if #(.EXP_W(5), .FRAC_W(10)) h_if ();

    fp_sqrt_iter #(.EXP_W(8), .FRAC_W(23)) u_s (.CLK(CLK), .RST(RST), .io(s_if));
    fp_sqrt_iter #(.EXP_W(5), .FRAC_W(10)) u_h (.CLK(CLK), .RST(RST), .io(h_if));

    typedef struct {
        logic [31:0] res;
        logic        inv;
        logic        unf;
        int          lat;
        int          k;
    } exp_t;

    exp_t sq[$];
    exp_t hq[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Latency is counted in rising edges from the accepting edge to the edge that samples enable high.
    logic s_en_prev = 1'b0;
    always @(negedge CLK) begin : mon_s
        exp_t e;
        if (s_if.enable) begin
            chk("s_enable_single_cycle", 32'(s_en_prev), 32'd0);
            if (sq.size() == 0) chk("s_unexpected_enable", 32'd1, 32'd0);
            else begin
                e = sq.pop_front();
                chk("s_result", s_if.result, e.res);
                chk("s_invalid", 32'(s_if.invalid), 32'(e.inv));
                chk("s_underflow", 32'(s_if.underflow), 32'(e.unf));
                chk("s_latency", 32'(cyc + 1 - e.k), 32'(e.lat));
            end
        end
        s_en_prev = s_if.enable;
    end

    logic h_en_prev = 1'b0;
    always @(negedge CLK) begin : mon_h
        exp_t e;
        if (h_if.enable) begin
            chk("h_enable_single_cycle", 32'(h_en_prev), 32'd0);
            if (hq.size() == 0) chk("h_unexpected_enable", 32'd1, 32'd0);
            else begin
                e = hq.pop_front();
                chk("h_result", 32'(h_if.result), e.res);
                chk("h_invalid", 32'(h_if.invalid), 32'(e.inv));
                chk("h_underflow", 32'(h_if.underflow), 32'(e.unf));
                chk("h_latency", 32'(cyc + 1 - e.k), 32'(e.lat));
            end
        end
        h_en_prev = h_if.enable;
    end

    task automatic issue_s(input logic [31:0] a, input logic [31:0] r, input logic inv,
                           input logic unf, input int lat, input bit push);
        int t = 0;
        @(negedge CLK);
        while (s_if.busy && t < 200) begin @(negedge CLK); t++; end
        if (t >= 200) chk("s_issue_timeout", 32'd1, 32'd0);
        s_if.A     = a;
        s_if.start = 1'b1;
        @(posedge CLK); #1;
        if (push) sq.push_back('{r, inv, unf, lat, cyc});
        chk("s_busy_after_accept", 32'(s_if.busy), 32'd1);
        s_if.start = 1'b0;
        s_if.A     = ~a;
    endtask

    task automatic drain_s();
        int t = 0;
        while ((sq.size() != 0 || s_if.busy) && t < 200) begin @(negedge CLK); t++; end
        if (t >= 200) chk("s_drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue_h(input logic [15:0] a, input logic [15:0] r, input logic inv,
                           input logic unf, input int lat);
        int t = 0;
        @(negedge CLK);
        while (h_if.busy && t < 200) begin @(negedge CLK); t++; end
        if (t >= 200) chk("h_issue_timeout", 32'd1, 32'd0);
        h_if.A     = a;
        h_if.start = 1'b1;
        @(posedge CLK); #1;
        hq.push_back('{32'(r), inv, unf, lat, cyc});
        chk("h_busy_after_accept", 32'(h_if.busy), 32'd1);
        h_if.start = 1'b0;
        h_if.A     = ~a;
        t = 0;
        while ((hq.size() != 0 || h_if.busy) && t < 200) begin @(negedge CLK); t++; end
        if (t >= 200) chk("h_drain_timeout", 32'd1, 32'd0);
    endtask

    // Positive normal half-precision operand: scale, take the real root, renormalise, round to nearest.
    function automatic logic [15:0] hmodel(input logic [15:0] a);
        real x;
        real m;
        int  ex;
        int  er;
        int  mi;
        ex = int'(a[14:10]);
        x  = 1.0 + real'(a[9:0]) / 1024.0;
        for (int i = 0; i < ex - 15; i++) x = x * 2.0;
        for (int i = 0; i < 15 - ex; i++) x = x / 2.0;
        m  = $sqrt(x);
        er = 15;
        while (m >= 2.0) begin m = m / 2.0; er++; end
        while (m < 1.0)  begin m = m * 2.0; er--; end
        mi = int'($floor(m * 1024.0 + 0.5));
        if (mi >= 2048) begin mi = 1024; er++; end
        return {1'b0, er[4:0], mi[9:0]};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0]  rex;
        logic [9:0]  rfr;
        logic [15:0] ra;
        s_if.start = 1'b0; s_if.A = '0;
        h_if.start = 1'b0; h_if.A = '0;
        repeat (3) @(negedge CLK);
        chk("rst_busy", 32'(s_if.busy), 32'd0);
        chk("rst_enable", 32'(s_if.enable), 32'd0);
        chk("rst_result", s_if.result, 32'd0);
        chk("rst_invalid", 32'(s_if.invalid), 32'd0);
        chk("rst_underflow", 32'(s_if.underflow), 32'd0);
        chk("rst_h_result", 32'(h_if.result), 32'd0);
        RST = 1'b1;

        issue_s(32'h40800000, 32'h40000000, 1'b0, 1'b0, S_LAT, 1'b1); drain_s();
        issue_s(32'h40000000, 32'h3FB504F3, 1'b0, 1'b0, S_LAT, 1'b1); drain_s();
        issue_s(32'h3E800000, 32'h3F000000, 1'b0, 1'b0, S_LAT, 1'b1); drain_s();
        issue_s(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, S_LAT, 1'b1); drain_s();
        issue_s(32'hC0800000, 32'h7FC00000, 1'b1, 1'b0, SP_LAT, 1'b1); drain_s();
        issue_s(32'h7F800000, 32'h7F800000, 1'b0, 1'b0, SP_LAT, 1'b1); drain_s();
        issue_s(32'h80000000, 32'h80000000, 1'b0, 1'b0, SP_LAT, 1'b1); drain_s();
        issue_s(32'h00000001, 32'h00000000, 1'b0, 1'b1, SP_LAT, 1'b1); drain_s();
        issue_s(32'h80000001, 32'h80000000, 1'b0, 1'b1, SP_LAT, 1'b1); drain_s();
        issue_s(32'hFF800000, 32'h7FC00000, 1'b1, 1'b0, SP_LAT, 1'b1); drain_s();
        issue_s(32'h7FA00001, 32'h7FE00001, 1'b0, 1'b0, SP_LAT, 1'b1); drain_s();
        issue_s(32'hFFA00000, 32'hFFE00000, 1'b0, 1'b0, SP_LAT, 1'b1); drain_s();

        // A second start during CALC must not disturb the operation in flight.
        issue_s(32'h40800000, 32'h40000000, 1'b0, 1'b0, S_LAT, 1'b1);
        repeat (4) @(negedge CLK);
        s_if.A = 32'hC0800000; s_if.start = 1'b1;
        @(negedge CLK);
        s_if.start = 1'b0;
        drain_s();

        // Asynchronous reset in the middle of a root, then a fresh operation.
        issue_s(32'h40000000, 32'h3FB504F3, 1'b0, 1'b0, S_LAT, 1'b0);
        repeat (9) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("midrst_busy", 32'(s_if.busy), 32'd0);
        chk("midrst_enable", 32'(s_if.enable), 32'd0);
        chk("midrst_result", s_if.result, 32'd0);
        chk("midrst_invalid", 32'(s_if.invalid), 32'd0);
        chk("midrst_underflow", 32'(s_if.underflow), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        issue_s(32'h40000000, 32'h3FB504F3, 1'b0, 1'b0, S_LAT, 1'b1); drain_s();

        issue_h(16'h4880, 16'h4200, 1'b0, 1'b0, H_LAT);
        issue_h(16'h7BFF, 16'h5BFF, 1'b0, 1'b0, H_LAT);
        issue_h(16'h3C00, 16'h3C00, 1'b0, 1'b0, H_LAT);
        issue_h(16'h4400, 16'h4000, 1'b0, 1'b0, H_LAT);
        issue_h(16'hFC00, 16'h7E00, 1'b1, 1'b0, SP_LAT);
        issue_h(16'h0200, 16'h0000, 1'b0, 1'b1, SP_LAT);
        for (int i = 0; i < 20; i++) begin
            rex = 5'($urandom_range(1, 30));
            rfr = 10'($urandom_range(0, 1023));
            ra  = {1'b0, rex, rfr};
            issue_h(ra, hmodel(ra), 1'b0, 1'b0, H_LAT);
        end

        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
